// File: rtl/regfile_mp_if.sv
// Bus bundle for the multi-port register file.
// Master drives addresses/writes/clear; slave returns read data and Busy.
interface regfile_mp_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2
);
    logic [NUM_RD*ADDR_WIDTH-1:0] ReadRegister;
    logic [NUM_RD*WIDTH-1:0]      ReadData;
    logic [ADDR_WIDTH-1:0]        WriteRegister0;
    logic [WIDTH-1:0]             WriteData0;
    logic                         RegWrite0;
    logic [ADDR_WIDTH-1:0]        WriteRegister1;
    logic [WIDTH-1:0]             WriteData1;
    logic                         RegWrite1;
    logic                         ClearReq;
    logic                         Busy;

    modport master (
        output ReadRegister,
        output WriteRegister0, WriteData0, RegWrite0,
        output WriteRegister1, WriteData1, RegWrite1,
        output ClearReq,
        input  ReadData, Busy
    );

    modport slave (
        input  ReadRegister,
        input  WriteRegister0, WriteData0, RegWrite0,
        input  WriteRegister1, WriteData1, RegWrite1,
        input  ClearReq,
        output ReadData, Busy
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-port register file: NUM_RD comb reads, two prioritised writes,
// optional bypass / zero register, and a one-entry-per-cycle clear engine.
module regfile_mp #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_RD     = 2,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 0
) (
    input  logic        Clk,
    input  logic        Rst_n,
    regfile_mp_if.slave rf
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] cnt;
    logic                  busy;

    logic [WIDTH-1:0]        mem [DEPTH];
    logic                    we0;
    logic                    we1;
    logic [ADDR_WIDTH-1:0]   ra [NUM_RD];
    logic [NUM_RD*WIDTH-1:0] rdata;

    // Busy masks writes, which also takes them out of the bypass path.
    assign we0 = rf.RegWrite0 && !busy &&
                 !((ZERO_REG != 0) && (rf.WriteRegister0 == '0));
    assign we1 = rf.RegWrite1 && !busy &&
                 !((ZERO_REG != 0) && (rf.WriteRegister1 == '0));

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (rf.ClearReq) begin
                        state <= CLEAR;
                        cnt   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    cnt <= cnt + 1'b1;
                    if (&cnt) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

    // Port 1 is assigned last so it wins an address collision.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (busy) begin
            mem[cnt] <= '0;
        end else begin
            if (we0) begin
                mem[rf.WriteRegister0] <= rf.WriteData0;
            end
            if (we1) begin
                mem[rf.WriteRegister1] <= rf.WriteData1;
            end
        end
    end

    always_comb begin
        rdata = '0;
        ra    = '{default: '0};
        for (int k = 0; k < NUM_RD; k++) begin
            ra[k] = rf.ReadRegister[k*ADDR_WIDTH +: ADDR_WIDTH];
            if ((ZERO_REG != 0) && (ra[k] == '0)) begin
                rdata[k*WIDTH +: WIDTH] = '0;
            end else if ((BYPASS != 0) && we1 &&
                         (ra[k] == rf.WriteRegister1)) begin
                rdata[k*WIDTH +: WIDTH] = rf.WriteData1;
            end else if ((BYPASS != 0) && we0 &&
                         (ra[k] == rf.WriteRegister0)) begin
                rdata[k*WIDTH +: WIDTH] = rf.WriteData0;
            end else begin
                rdata[k*WIDTH +: WIDTH] = mem[ra[k]];
            end
        end
    end

    assign rf.ReadData = rdata;
    assign rf.Busy     = busy;
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file; the next generation of the 32x32 two-read/one-write register file used by the single-cycle CPU datapath.
- Width and depth are configurable. It has a configurable number of read ports and two write ports with fixed priority.
- Optional write-to-read bypass and optional hardwired zero register.
- A background clear engine zeroes the array one entry per cycle, so software-visible reset does not need the async reset.

Parameters:
- WIDTH, 32, data bits per register.
- ADDR_WIDTH, 5, address bits; DEPTH = 2**ADDR_WIDTH entries.
- NUM_RD, 2, number of read ports (1..8).
- ZERO_REG, 1, if 1 then register 0 always reads 0 and ignores writes.
- BYPASS, 0, if 1 then a read of an address being written this cycle returns the new data combinationally.

Ports:
- Clk  in  1  clock, posedge.
- Rst_n  in  1  asynchronous active-low reset.
- ReadRegister  in  NUM_RD*ADDR_WIDTH  read addresses; port k uses bits [k*ADDR_WIDTH +: ADDR_WIDTH].
- ReadData  out  NUM_RD*WIDTH  read data; port k uses bits [k*WIDTH +: WIDTH].
- WriteRegister0  in  ADDR_WIDTH  write port 0 address.
- WriteData0  in  WIDTH  write port 0 data.
- RegWrite0  in  1  write port 0 enable.
- WriteRegister1  in  ADDR_WIDTH  write port 1 address.
- WriteData1  in  WIDTH  write port 1 data.
- RegWrite1  in  1  write port 1 enable.
- ClearReq  in  1  start the background clear; sampled at posedge.
- Busy  out  1  high while a clear is in progress.

Behaviour:
- Reset (Rst_n=0, async):
  - All DEPTH entries go to 0 immediately.
  - Clear FSM goes to IDLE, clear counter goes to 0, Busy=0.
  - ReadData reflects zeros combinationally.
- Reads:
  - Combinational, zero latency, independent per port.
  - Any number of ports may read the same address.
- Writes:
  - Take effect on posedge Clk when RegWrite is high.
  - Visible on ReadData after the edge (latency 1 with BYPASS=0).
- Write conflict: both enables high with equal addresses -> port 1 data is stored; port 0 is discarded.
- ZERO_REG=1:
  - Writes to address 0 are dropped on both ports.
  - Reads of address 0 return 0 regardless of bypass.
- BYPASS=1:
  - ReadData[k] = WriteData1 if RegWrite1 and the address matches port 1.
  - Else WriteData0 if RegWrite0 and the address matches port 0.
  - Else the stored value.
  - The ZERO_REG and Busy rules take precedence over bypass.
- Clear FSM states IDLE, CLEAR:
  - IDLE: ClearReq=1 at posedge -> CLEAR; counter=0; Busy=1 from the next cycle.
  - CLEAR: each posedge zeroes entry[counter] and increments counter. When entry DEPTH-1 is cleared -> IDLE, Busy=0 on the following cycle.
  - A full clear takes exactly DEPTH cycles of Busy=1.
  - ClearReq while in CLEAR is ignored; the clear does not restart.
  - While Busy=1, all writes on both ports are dropped and bypass is disabled.
  - Reads during CLEAR return current stored contents: already-cleared entries read 0, others keep old values.
- Reset asserted mid-clear: the array is fully zeroed and the FSM returns to IDLE immediately; no residual Busy.
- The counter is ADDR_WIDTH bits and wraps to 0 on exit. No arithmetic is performed on data.

Test Plan:
1. Reset, write 42 to reg 2 via port 0 with ReadRegister ports 0 and 1 = 2 -> both read 0 before the edge and 42 after the edge. With BYPASS=1 both read 42 in the same cycle.
2. RegWrite0=0, WriteRegister0=10, WriteData0=15, one edge -> reg 10 reads 0. Then write 15 to reg 15 -> port 0 (addr 15) reads 15 and port 1 (addr 20) reads 0.
3. Both ports write reg 7 in the same cycle, port 0 with 0xAAAA_AAAA and port 1 with 0x5555_5555 -> reg 7 reads 0x5555_5555. Both write to different regs 3 and 4 -> both stored.
4. ZERO_REG=1: write 15 to reg 0 on both ports (BYPASS=1) -> reg 0 reads 0 in the same cycle and after the edge.
5. Fill all 32 regs with value = index+100, pulse ClearReq:
   - Busy is high for exactly 32 cycles.
   - After cycle 5 of Busy, regs 0-4 read 0 and reg 31 reads 131.
   - A write to reg 31 during Busy is dropped.
   - After Busy falls, all regs read 0.
6. Start a clear and assert Rst_n=0 at Busy cycle 10 -> Busy=0 and all regs read 0 immediately. After release, a write of 9 to reg 12 succeeds on the next edge.
